// File: rtl/rio_pkg.sv
// Shared constants, state encoding and header helpers for the remote-IO SPI frame path.
package rio_pkg;

  localparam logic [31:0] MSGID_WRTI = 32'h74697277;
  localparam logic [31:0] HDR_DATA   = 32'h64617461;
  localparam logic [31:0] HDR_ESTP   = 32'h65737470;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_FAULT   = 2'd3
  } gate_state_e;

  // Headers travel LSB byte first, so the top 32 frame bits are byte-reversed.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rio_watchdog.sv
// Comms-loss watchdog: counts cycles since the last kick, saturating at LIMIT-1.
module rio_watchdog #(
  parameter int unsigned LIMIT = 6750000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (kick) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/rx_frame_gate.sv
// Validates incoming SPI frames by header, forwards good ones, blanks outputs on
// comms loss or repeated bad headers, and registers the outgoing tx header.
module rx_frame_gate
  import rio_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 248,
  parameter logic [31:0] MSGID       = MSGID_WRTI,
  parameter int unsigned TIMEOUT     = 32'd6750000,
  parameter int unsigned MAX_BAD     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_valid,
  input  logic [BUFFER_SIZE-1:0] rx_data,
  input  logic                   estop,
  output logic [BUFFER_SIZE-1:0] rx_data_q,
  output logic                   frame_strobe,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             bad_cnt,
  output logic                   timeout,
  output logic [31:0]            header_tx
);

  localparam logic [3:0] BAD_LIM = 4'(MAX_BAD);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
    return (v == BAD_LIM) ? v : v + 4'd1;
  endfunction

  gate_state_e              state, state_nxt;
  logic                     vld_p0, hdr_ok_p0;
  logic [BUFFER_SIZE-1:0]   rx_data_p0;
  logic                     hdr_ok, good, bad;
  logic                     fwd, clr_q, wd_kick, wd_expired;
  logic                     fault_arm, fault_arm_nxt;
  logic [3:0]               bad_run;

  assign hdr_ok = (bswap32(rx_data[BUFFER_SIZE-1 -: 32]) == MSGID);

  // ---- stage p0: capture frame and header verdict ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      hdr_ok_p0 <= 1'b0;
    end else begin
      vld_p0    <= frame_valid;
      hdr_ok_p0 <= hdr_ok;
    end
  end

  always_ff @(posedge clk) begin
    rx_data_p0 <= rx_data;
  end

  // ---- stage p1: FSM, latching and counters ----
  assign good = vld_p0 && hdr_ok_p0;
  assign bad  = vld_p0 && !hdr_ok_p0;

  // Watchdog only runs while in RUN; anything else holds it at zero.
  assign wd_kick = (state != ST_RUN) || good;

  rio_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (wd_kick),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt     = state;
    fwd           = 1'b0;
    clr_q         = 1'b0;
    fault_arm_nxt = fault_arm;
    case (state)
      ST_IDLE, ST_TIMEOUT: begin
        if (good) begin
          state_nxt = ST_RUN;
          fwd       = 1'b1;
        end
      end
      ST_RUN: begin
        if (good) begin
          fwd = 1'b1;
        end else if (bad && (sat_inc_run(bad_run) == BAD_LIM)) begin
          state_nxt     = ST_FAULT;
          clr_q         = 1'b1;
          fault_arm_nxt = 1'b0;
        end else if (wd_expired) begin
          state_nxt = ST_TIMEOUT;
          clr_q     = 1'b1;
        end
      end
      ST_FAULT: begin
        // Recovery needs two good frames in a row; the first only arms it.
        if (good) begin
          if (fault_arm) begin
            state_nxt     = ST_RUN;
            fwd           = 1'b1;
            fault_arm_nxt = 1'b0;
          end else begin
            fault_arm_nxt = 1'b1;
          end
        end else if (bad) begin
          fault_arm_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fault_arm    <= 1'b0;
      bad_run      <= '0;
      rx_data_q    <= '0;
      frame_strobe <= 1'b0;
      frame_cnt    <= '0;
      bad_cnt      <= '0;
      timeout      <= 1'b1;
      header_tx    <= HDR_DATA;
    end else begin
      state        <= state_nxt;
      fault_arm    <= fault_arm_nxt;
      frame_strobe <= fwd;
      if (fwd) begin
        rx_data_q <= rx_data_p0;
      end else if (clr_q) begin
        rx_data_q <= '0;
      end
      if (good) begin
        frame_cnt <= frame_cnt + 16'd1;
        bad_run   <= '0;
      end else if (bad) begin
        bad_cnt <= sat_inc8(bad_cnt);
        bad_run <= sat_inc_run(bad_run);
      end
      timeout   <= (state != ST_RUN);
      header_tx <= (estop || state == ST_FAULT) ? HDR_ESTP : HDR_DATA;
    end
  end

endmodule
